// File: rtl/sl_stripe_source.sv
// Structured-light stripe source: plays white, black, 10 Gray-code planes
// and 10 inverted planes, each held HOLD_FRAMES frames, with a camera trigger.
// Ports: clock_pixel/reset (sync, active-high), iSyncV (active-low vsync from
// the output stage), iStart; oRed/oGreen/oBlue pixel data, oPatIdx, oTrigger,
// oBusy, oDone, oLocked. Raster geometry defaults to the 800x525 timing.
module sl_stripe_source #(
  parameter int unsigned HOLD_FRAMES  = 4,
  parameter logic [23:0] STRIPE_COLOR = 24'hFFFFFF,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned SYNC_LINE    = 490
) (
  input  logic       clock_pixel,
  input  logic       reset,
  input  logic       iSyncV,
  input  logic       iStart,
  output logic [7:0] oRed,
  output logic [7:0] oGreen,
  output logic [7:0] oBlue,
  output logic [4:0] oPatIdx,
  output logic       oTrigger,
  output logic       oBusy,
  output logic       oDone,
  output logic       oLocked
);

  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] Y_SYNC = 10'(SYNC_LINE);
  localparam logic [3:0] F_LAST = 4'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t      state, state_n;
  logic [9:0]  x, y;
  logic        prev, locked;
  logic [4:0]  idx, idx_n;
  logic [3:0]  fcnt, fcnt_n;
  logic        trig, trig_n;
  logic [23:0] rgb;
  logic        sync_edge, frame_start;
  logic [9:0]  gray;
  logic [3:0]  bsel;
  logic        sbit, active;

  assign sync_edge   = prev & ~iSyncV;
  // A reload on the same edge suppresses the frame start.
  assign frame_start = ~sync_edge & (x == X_LAST) & (y == Y_LAST);
  assign active      = (x < X_ACT) && (y < Y_ACT);
  assign gray        = x ^ {1'b0, x[9:1]};

  always_ff @(posedge clock_pixel) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      prev   <= 1'b1;
      locked <= 1'b0;
    end else begin
      prev <= iSyncV;
      if (sync_edge) begin
        // Output stage column is 2 by the time this edge completes.
        x      <= 10'd2;
        y      <= Y_SYNC;
        locked <= 1'b1;
      end else if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  always_comb begin
    sbit = 1'b0;
    bsel = '0;
    if (idx == 5'd0) begin
      sbit = 1'b1;
    end else if (idx == 5'd1) begin
      sbit = 1'b0;
    end else if (idx <= 5'd11) begin
      bsel = 4'(5'd11 - idx);
      sbit = gray[bsel];
    end else begin
      bsel = 4'(5'd21 - idx);
      sbit = ~gray[bsel];
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    fcnt_n  = fcnt;
    trig_n  = 1'b0;
    unique case (state)
      IDLE: begin
        idx_n  = '0;
        fcnt_n = '0;
        if (iStart && locked) state_n = ARM;
      end
      ARM: begin
        if (frame_start) begin
          state_n = RUN;
          idx_n   = '0;
          fcnt_n  = '0;
        end
      end
      RUN: begin
        if (frame_start) begin
          if (fcnt == F_LAST) begin
            fcnt_n = '0;
            if (idx == 5'd21) state_n = DONE;
            else              idx_n   = idx + 5'd1;
          end else begin
            fcnt_n = fcnt + 4'd1;
            trig_n = (fcnt == 4'd0);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_pixel) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      fcnt  <= '0;
      trig  <= 1'b0;
      rgb   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      fcnt  <= fcnt_n;
      trig  <= trig_n;
      rgb   <= (state == RUN && active && sbit) ? STRIPE_COLOR : '0;
    end
  end

  assign {oRed, oGreen, oBlue} = rgb;
  assign oPatIdx  = idx;
  assign oTrigger = trig;
  assign oBusy    = (state == ARM) || (state == RUN);
  assign oDone    = (state == DONE);
  assign oLocked  = locked;

endmodule
